// File: rtl/lu_pkg.sv
// Shared types for the 3x3 LU solver: FSM states, Q16.16 widths,
// micro-step table and seven-segment codes.
package lu_pkg;

  localparam int QW = 32;
  localparam int QF = 16;

  typedef enum logic [2:0] {
    IDLE, LU, FWD, BACK, DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_M1, PH_M2, PH_DS, PH_DW, PH_WR
  } phase_t;

  // r = c - p1*q1 - p2*q2, optionally divided by d
  typedef struct packed {
    logic [4:0] c;
    logic [4:0] p1;
    logic [4:0] q1;
    logic [4:0] p2;
    logic [4:0] q2;
    logic [4:0] d;
    logic [1:0] nmul;
    logic       div;
  } uop_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic uop_t mk(
    input int c, input int p1, input int q1,
    input int p2, input int q2, input int d,
    input int nm, input int dv
  );
    uop_t u;
    u.c    = 5'(c);
    u.p1   = 5'(p1);
    u.q1   = 5'(q1);
    u.p2   = 5'(p2);
    u.q2   = 5'(q2);
    u.d    = 5'(d);
    u.nmul = 2'(nm);
    u.div  = 1'(dv);
    return u;
  endfunction

  // operand index: 0-8 a11..a33, 9-11 b1..b3, 12+k working reg k
  function automatic uop_t uop(input logic [3:0] s);
    case (s)
      4'd0:    return mk(3, 0, 0, 0, 0, 0, 0, 1);
      4'd1:    return mk(6, 0, 0, 0, 0, 0, 0, 1);
      4'd2:    return mk(4, 12, 1, 0, 0, 0, 1, 0);
      4'd3:    return mk(5, 12, 2, 0, 0, 0, 1, 0);
      4'd4:    return mk(7, 13, 1, 0, 0, 14, 1, 1);
      4'd5:    return mk(8, 13, 2, 16, 15, 0, 2, 0);
      4'd6:    return mk(10, 12, 9, 0, 0, 0, 1, 0);
      4'd7:    return mk(11, 13, 9, 16, 18, 0, 2, 0);
      4'd8:    return mk(19, 0, 0, 0, 0, 17, 0, 1);
      4'd9:    return mk(18, 15, 20, 0, 0, 14, 1, 1);
      4'd10:   return mk(9, 1, 21, 2, 20, 0, 2, 1);
      default: return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endcase
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_F;
    endcase
  endfunction

  function automatic logic [3:0] dec_digit(
    input logic [13:0] v, input logic [1:0] pos
  );
    logic [13:0] t;
    case (pos)
      2'd0:    t = v;
      2'd1:    t = v / 14'd10;
      2'd2:    t = v / 14'd100;
      default: t = v / 14'd1000;
    endcase
    return 4'(t % 14'd10);
  endfunction

endpackage

// File: rtl/lu_fixed_divider.sv
// Signed sequential Q16.16 divider: (num<<16)/den, truncated toward
// zero, one quotient bit per cycle, 49 cycles from start to done.
module lu_fixed_divider
  import lu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [QW-1:0] num,
  input  logic [QW-1:0] den,
  output logic          done,
  output logic          dbz,
  output logic          ovf,
  output logic [QW-1:0] quo
);

  logic          run;
  logic          neg;
  logic [5:0]    cnt;
  logic [31:0]   rem;
  logic [47:0]   q;
  logic [31:0]   dm;
  logic [31:0]   nmag;
  logic [31:0]   dmag;
  logic [32:0]   sh;
  logic [32:0]   rn;
  logic          ge;
  logic [47:0]   qn;
  logic          qovf;
  logic [31:0]   qs;
  logic          unused_bits;

  always_comb begin
    nmag = num[31] ? -num : num;
    dmag = den[31] ? -den : den;
    sh   = {rem, q[47]};
    ge   = sh >= {1'b0, dm};
    rn   = ge ? sh - {1'b0, dm} : sh;
    qn   = {q[46:0], ge};
    qovf = neg ? (qn > 48'h0000_8000_0000)
               : (qn > 48'h0000_7FFF_FFFF);
    qs   = neg ? -qn[31:0] : qn[31:0];
  end

  assign unused_bits = rn[32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      neg  <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      q    <= '0;
      dm   <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
      ovf  <= 1'b0;
      quo  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (den == '0) begin
          done <= 1'b1;
          dbz  <= 1'b1;
          ovf  <= 1'b0;
          quo  <= '0;
          run  <= 1'b0;
        end else begin
          dbz <= 1'b0;
          run <= 1'b1;
          cnt <= 6'd48;
          rem <= '0;
          q   <= {nmag, 16'h0000};
          dm  <= dmag;
          neg <= num[31] ^ den[31];
        end
      end else if (run) begin
        rem <= rn[31:0];
        q   <= qn;
        cnt <= cnt - 6'd1;
        if (cnt == 6'd1) begin
          run  <= 1'b0;
          done <= 1'b1;
          ovf  <= qovf;
          quo  <= qs;
        end
      end
    end
  end

endmodule

// File: rtl/main_3_vari_equation_solver.sv
// 3x3 Doolittle LU solver in Q16.16 with seven-segment readout.
// SOLVER_ROUND_EN selects rounded instead of truncated fraction digits.
module main_3_vari_equation_solver
  import lu_pkg::*;
#(
  parameter logic [287:0] A_INIT = {
    32'h0002_0000, 32'h0001_0000, 32'h0001_0000,
    32'h0004_0000, 32'hFFFA_0000, 32'h0000_0000,
    32'hFFFE_0000, 32'h0007_0000, 32'h0002_0000
  },
  parameter logic [95:0] B_INIT = {
    32'h0005_0000, 32'hFFFE_0000, 32'h0009_0000
  }
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LU_en,
  input  logic [4:0] disp_control,
  output logic       LU_done,
  output logic       LU_error_ovf,
  output logic       LU_error_dbz,
  output logic       LU_error_FSM,
  output logic       test,
  output logic [6:0] seg7_neg_sign,
  output logic [6:0] seg7_thousand,
  output logic [6:0] seg7_hundred,
  output logic [6:0] seg7_ten,
  output logic [6:0] seg7_one,
  output logic [6:0] seg7_tenth,
  output logic [6:0] seg7_centi,
  output logic [6:0] seg7_milli,
  output logic [6:0] seg7_tenth_milli
);

`ifdef SOLVER_ROUND_EN
  localparam logic [29:0] RND = 30'd32768;
`else
  localparam logic [29:0] RND = 30'd0;
`endif

  state_t             state;
  phase_t             ph;
  logic [3:0]         step;
  logic [QW-1:0]      acc;
  logic [QW-1:0]      w [11];
  logic [QW-1:0]      rf [32];
  logic               ovf_r;
  uop_t               op;
  logic               busy;
  logic               wr_en;
  logic [QW-1:0]      wr_val;
  logic [QW-1:0]      ma;
  logic [QW-1:0]      mb;
  logic signed [63:0] prod;
  logic [QW-1:0]      mres;
  logic               movf;
  logic [QW-1:0]      sub_a;
  logic [32:0]        diff;
  logic               sovf;
  logic               dv_start;
  logic               dv_done;
  logic               dv_dbz;
  logic               dv_ovf;
  logic [QW-1:0]      dv_q;

  always_comb begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    for (int i = 0; i < 9; i++) rf[i] = A_INIT[287-32*i -: 32];
    for (int i = 0; i < 3; i++) rf[9+i] = B_INIT[95-32*i -: 32];
    for (int i = 0; i < 11; i++) rf[12+i] = w[i];
  end

  // the single shared multiplier and its accumulate/subtract path
  always_comb begin
    op    = uop(step);
    busy  = (state == LU) || (state == FWD) || (state == BACK);
    ma    = (ph == PH_M2) ? rf[op.p2] : rf[op.p1];
    mb    = (ph == PH_M2) ? rf[op.q2] : rf[op.q1];
    prod  = $signed(ma) * $signed(mb);
    mres  = prod[47:16];
    movf  = !((&prod[63:47]) || !(|prod[63:47]));
    sub_a = (ph == PH_M1) ? rf[op.c] : acc;
    diff  = {sub_a[31], sub_a} - {mres[31], mres};
    sovf  = diff[32] ^ diff[31];
    wr_en = busy && ((ph == PH_WR) ||
            (ph == PH_DW && dv_done && !dv_dbz));
    wr_val   = (ph == PH_WR) ? acc : dv_q;
    dv_start = busy && (ph == PH_DS);
  end

  lu_fixed_divider u_div (
    .clk   (clk),
    .rst_n (rst),
    .start (dv_start),
    .num   (acc),
    .den   (rf[op.d]),
    .done  (dv_done),
    .dbz   (dv_dbz),
    .ovf   (dv_ovf),
    .quo   (dv_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ph           <= PH_M1;
      step         <= '0;
      acc          <= '0;
      ovf_r        <= 1'b0;
      LU_done      <= 1'b0;
      LU_error_dbz <= 1'b0;
      LU_error_FSM <= 1'b0;
      test         <= 1'b0;
      for (int i = 0; i < 11; i++) w[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (LU_en) begin
            state        <= LU;
            ph           <= PH_M1;
            step         <= '0;
            ovf_r        <= 1'b0;
            LU_error_dbz <= 1'b0;
            LU_error_FSM <= 1'b0;
            test         <= 1'b1;
          end
        end
        LU, FWD, BACK: begin
          if (wr_en) begin
            w[step] <= wr_val;
            step    <= step + 4'd1;
            ph      <= PH_M1;
            if (ph == PH_DW) ovf_r <= ovf_r | dv_ovf;
            if (step == 4'd5) state <= FWD;
            else if (step == 4'd7) state <= BACK;
            else if (step == 4'd10) begin
              state   <= DONE;
              LU_done <= 1'b1;
              test    <= 1'b0;
            end
          end else begin
            unique case (ph)
              PH_M1: begin
                acc <= (op.nmul != 2'd0) ? diff[31:0] : sub_a;
                if (op.nmul != 2'd0) ovf_r <= ovf_r | movf | sovf;
                ph <= (op.nmul == 2'd2) ? PH_M2 :
                      op.div ? PH_DS : PH_WR;
              end
              PH_M2: begin
                acc   <= diff[31:0];
                ovf_r <= ovf_r | movf | sovf;
                ph    <= op.div ? PH_DS : PH_WR;
              end
              PH_DS: ph <= PH_DW;
              PH_DW: begin
                if (dv_done && dv_dbz) begin
                  LU_error_dbz <= 1'b1;
                  state        <= DONE;
                  LU_done      <= 1'b1;
                  test         <= 1'b0;
                  for (int i = 0; i < 11; i++) w[i] <= '0;
                end
              end
              default: ph <= PH_M1;
            endcase
          end
        end
        DONE: begin
          if (!LU_en) begin
            state   <= IDLE;
            LU_done <= 1'b0;
          end
        end
        default: begin
          LU_error_FSM <= 1'b1;
          state        <= DONE;
          LU_done      <= 1'b1;
          test         <= 1'b0;
        end
      endcase
    end
  end

  logic [QW-1:0] xs;
  logic [QW-1:0] mag;
  logic [29:0]   fp;
  logic [13:0]   frac;
  logic [13:0]   fr;
  logic [16:0]   ival;
  logic [13:0]   iv;
  logic [13:0]   fv;
  logic          dovf;
  logic          tmode;
  logic          unused_bits;

  always_comb begin
    tmode = disp_control[1:0] == 2'b11;
    unique case (disp_control[1:0])
      2'b00:   xs = w[10];
      2'b01:   xs = w[9];
      default: xs = w[8];
    endcase
    mag  = xs[31] ? -xs : xs;
    fp   = 30'(mag[15:0]) * 30'd10000 + RND;
    frac = fp[29:16];
    // a rounded fraction of exactly 1.0000 carries into the integer
    ival = {1'b0, mag[31:16]} + 17'(frac == 14'd10000);
    fr   = (frac == 14'd10000) ? 14'd0 : frac;
    dovf = ival > 17'd9999;
    iv   = dovf ? 14'd9999 : ival[13:0];
    fv   = dovf ? 14'd9999 : fr;
  end

  assign unused_bits = ^{disp_control[4:2], prod[15:0], fp[15:0]};

  assign LU_error_ovf = ovf_r | (dovf & ~tmode);

  assign seg7_neg_sign = (!tmode && xs[31]) ? SEG_MINUS : SEG_BLANK;
  assign seg7_thousand =
    tmode ? SEG_F : seg_digit(dec_digit(iv, 2'd3));
  assign seg7_hundred =
    tmode ? SEG_F : seg_digit(dec_digit(iv, 2'd2));
  assign seg7_ten =
    tmode ? SEG_F : seg_digit(dec_digit(iv, 2'd1));
  assign seg7_one =
    tmode ? SEG_F : seg_digit(dec_digit(iv, 2'd0));
  assign seg7_tenth =
    tmode ? SEG_F : seg_digit(dec_digit(fv, 2'd3));
  assign seg7_centi =
    tmode ? SEG_F : seg_digit(dec_digit(fv, 2'd2));
  assign seg7_milli =
    tmode ? SEG_F : seg_digit(dec_digit(fv, 2'd1));
  assign seg7_tenth_milli =
    tmode ? SEG_F : seg_digit(dec_digit(fv, 2'd0));

endmodule

// File: tb/tb_main_3_vari_equation_solver.sv
// Bench: six solver instances with different systems, scoreboard of
// expected displays/flags compared once every instance reports done.
module tb_main_3_vari_equation_solver;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       LU_en = 1'b0;
  logic [4:0] disp_control = 5'd0;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] done_w;
  logic [N-1:0] ovf_w;
  logic [N-1:0] dbz_w;
  logic [N-1:0] fsm_w;
  logic [N-1:0] test_w;
  logic [62:0]  seg_w [N];

  typedef struct packed {
    logic [2:0]  inst;
    logic [1:0]  sel;
    logic [62:0] seg;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] q(input int v);
    return 32'(v <<< 16);
  endfunction

  function automatic logic [287:0] mat(
    input int a, input int b, input int c,
    input int d, input int e, input int f,
    input int g, input int h, input int k
  );
    return {q(a), q(b), q(c), q(d), q(e), q(f), q(g), q(h), q(k)};
  endfunction

  function automatic logic [287:0] a_of(input int k);
    case (k)
      0, 1:    return mat(2, 1, 1, 4, -6, 0, -2, 7, 2);
      2, 3:    return mat(3, 0, 0, 0, 1, 0, 0, 0, 1);
      4:       return mat(0, 1, 1, 4, -6, 0, -2, 7, 2);
      default: return mat(1, 0, 0, 0, 1, 0, 0, 0, 1);
    endcase
  endfunction

  function automatic logic [95:0] b_of(input int k);
    case (k)
      0, 4:    return {q(5), q(-2), q(9)};
      1:       return {q(-5), q(2), q(-9)};
      2:       return {q(1), q(0), q(0)};
      3:       return {q(2), q(0), q(0)};
      default: return {q(20000), q(0), q(0)};
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [6:0] s [9];
    assign seg_w[g] = {s[0], s[1], s[2], s[3], s[4],
                       s[5], s[6], s[7], s[8]};
    main_3_vari_equation_solver #(
      .A_INIT (a_of(g)),
      .B_INIT (b_of(g))
    ) dut (
      .clk              (clk),
      .rst              (rst),
      .LU_en            (LU_en),
      .disp_control     (disp_control),
      .LU_done          (done_w[g]),
      .LU_error_ovf     (ovf_w[g]),
      .LU_error_dbz     (dbz_w[g]),
      .LU_error_FSM     (fsm_w[g]),
      .test             (test_w[g]),
      .seg7_neg_sign    (s[0]),
      .seg7_thousand    (s[1]),
      .seg7_hundred     (s[2]),
      .seg7_ten         (s[3]),
      .seg7_one         (s[4]),
      .seg7_tenth       (s[5]),
      .seg7_centi       (s[6]),
      .seg7_milli       (s[7]),
      .seg7_tenth_milli (s[8])
    );
  end

  function automatic logic [6:0] enc(input byte c);
    case (c)
      "0": return 7'b0000001;
      "1": return 7'b1001111;
      "2": return 7'b0010010;
      "3": return 7'b0000110;
      "4": return 7'b1001100;
      "5": return 7'b0100100;
      "6": return 7'b0100000;
      "7": return 7'b0001111;
      "8": return 7'b0000000;
      "9": return 7'b0001100;
      "F": return 7'b0111000;
      "-": return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  // "+dddd.dddd" -> sign and eight digits, sign in the MSBs
  function automatic logic [62:0] exp_seg(input string s);
    logic [62:0] r;
    int k;
    r = '0;
    r[62:56] = enc(s[0]);
    k = 7;
    for (int i = 1; i < 10; i++) begin
      if (i != 5) begin
        r[k*7 +: 7] = enc(s[i]);
        k--;
      end
    end
    return r;
  endfunction

  task automatic push(
    input int inst, input int sel, input string s,
    input bit ovf, input bit dbz
  );
    exp_t e;
    e.inst = 3'(inst);
    e.sel  = 2'(sel);
    e.seg  = exp_seg(s);
    e.ovf  = ovf;
    e.dbz  = dbz;
    sb.push_back(e);
  endtask

  task automatic push_all();
`ifdef SOLVER_ROUND_EN
    string two_thirds = "+0000.6667";
`else
    string two_thirds = "+0000.6666";
`endif
    push(0, 0, "+0001.0000", 0, 0);
    push(0, 1, "+0001.0000", 0, 0);
    push(0, 2, "+0002.0000", 0, 0);
    push(1, 0, "-0001.0000", 0, 0);
    push(1, 1, "-0001.0000", 0, 0);
    push(1, 2, "-0002.0000", 0, 0);
    push(2, 0, "+0000.3333", 0, 0);
    push(2, 1, "+0000.0000", 0, 0);
    push(3, 0, two_thirds, 0, 0);
    push(4, 0, "+0000.0000", 0, 1);
    push(4, 2, "+0000.0000", 0, 1);
    push(5, 0, "+9999.9999", 1, 0);
    push(5, 1, "+0000.0000", 0, 0);
  endtask

  task automatic start_and_wait(output int lat, output bit to);
    lat = 0;
    to  = 1'b1;
    @(negedge clk);
    LU_en = 1'b1;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (done_w[0] && lat == 0) lat = c;
      if (&done_w) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      disp_control = {3'b101, e.sel};
      #1;
      checks++;
      if (seg_w[e.inst] !== e.seg) begin
        failures++;
        $display("FAIL seg inst=%0d sel=%0d got=%h want=%h",
                 e.inst, e.sel, seg_w[e.inst], e.seg);
      end
      checks++;
      if (ovf_w[e.inst] !== e.ovf || dbz_w[e.inst] !== e.dbz) begin
        failures++;
        $display("FAIL flags inst=%0d sel=%0d ovf/dbz got=%b%b want=%b%b",
                 e.inst, e.sel, ovf_w[e.inst], dbz_w[e.inst],
                 e.ovf, e.dbz);
      end
      checks++;
      if (done_w[e.inst] !== 1'b1 || fsm_w[e.inst] !== 1'b0) begin
        failures++;
        $display("FAIL done inst=%0d done/fsm got=%b%b want=10",
                 e.inst, done_w[e.inst], fsm_w[e.inst]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      checks++;
      if ({done_w[i], ovf_w[i], dbz_w[i], fsm_w[i], test_w[i]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_flags inst=%0d got=%b%b%b%b%b want=00000",
                 i, done_w[i], ovf_w[i], dbz_w[i], fsm_w[i], test_w[i]);
      end
      checks++;
      if (seg_w[i] !== exp_seg("+0000.0000")) begin
        failures++;
        $display("FAIL reset_seg inst=%0d got=%h want=%h",
                 i, seg_w[i], exp_seg("+0000.0000"));
      end
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_solve();
    int lat;
    bit to;
    push_all();
    start_and_wait(lat, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL solve_timeout done=%b want=%b", done_w, {N{1'b1}});
    end
    checks++;
    if (lat < 1 || lat > 600) begin
      failures++;
      $display("FAIL latency got=%0d want=1..600", lat);
    end
    drain();
  endtask

  task automatic test_pattern();
    @(negedge clk);
    disp_control = 5'd11;
    #1;
    for (int i = 0; i < N; i++) begin
      checks++;
      if (seg_w[i] !== exp_seg(" FFFF.FFFF")) begin
        failures++;
        $display("FAIL pattern inst=%0d got=%h want=%h",
                 i, seg_w[i], exp_seg(" FFFF.FFFF"));
      end
    end
  endtask

  task automatic test_handshake();
    repeat (5) @(negedge clk);
    checks++;
    if (done_w !== {N{1'b1}}) begin
      failures++;
      $display("FAIL done_hold got=%b want=%b", done_w, {N{1'b1}});
    end
    LU_en = 1'b0;
    @(negedge clk);
    checks++;
    if (done_w !== '0 || test_w !== '0) begin
      failures++;
      $display("FAIL done_drop done=%b test=%b want=0", done_w, test_w);
    end
  endtask

  task automatic test_back_to_back();
    test_solve();
    test_handshake();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    disp_control = 5'd0;
    LU_en = 1'b1;
    repeat (100) @(negedge clk);
    checks++;
    if (test_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      failures++;
      $display("FAIL busy test/done got=%b%b want=10",
               test_w[0], done_w[0]);
    end
    #2;
    rst = 1'b0;
    LU_en = 1'b0;
    #1;
    checks++;
    if (done_w !== '0 || test_w !== '0 || dbz_w !== '0) begin
      failures++;
      $display("FAIL midreset done=%b test=%b dbz=%b want=0",
               done_w, test_w, dbz_w);
    end
    checks++;
    if (seg_w[0] !== exp_seg("+0000.0000")) begin
      failures++;
      $display("FAIL midreset_seg got=%h want=%h",
               seg_w[0], exp_seg("+0000.0000"));
    end
    @(negedge clk);
    rst = 1'b1;
    test_solve();
  endtask

  initial begin
    test_reset();
    test_solve();
    test_pattern();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
